// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Round-level controller for the AES-128 encryption datapath. Accepts one
// 128-bit plaintext block, then walks the AES-128 round schedule by issuing
// start pulses to the external subbytes, shiftrows, mixcolumns and
// addroundkey units and waiting for their finish strobes. The working state is
// held here between operations and the finished ciphertext is presented with a
// valid/ready handshake.
//
// Schedule: round 0 = ARK; rounds 1..9 = SB, SR, MC, ARK; round 10 = SB, SR,
// ARK (40 unit operations). Each operation costs ISSUE + WAIT + NEXT.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   in_valid / in_ready           plaintext handshake (in_ready only in IDLE)
//   plaintext[127:0]              input block, byte 0 in bits [127:120]
//   unit_state[127:0]             working state, fanned out to every unit
//   roundnumber[3:0]              current round (0..10) for addroundkey
//   *_start / *_finish            per-unit one-cycle start, completion strobe
//   *_result[127:0]               per-unit result
//   out_valid / out_ready         ciphertext handshake
//   ciphertext[127:0]             finished block (mirrors unit_state)
//   busy                          high in ISSUE, WAIT and NEXT
//   error                         sticky watchdog flag, cleared only by rst
//
// Parameter TIMEOUT: number of WAIT cycles tolerated for one unit; when the
// selected unit has not finished after TIMEOUT WAIT cycles the block locks in
// ERR (8-bit watchdog, so 1..255).
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  output logic [127:0] unit_state,
  output logic [3:0]   roundnumber,
  output logic         sb_start,
  output logic         sr_start,
  output logic         mc_start,
  output logic         ark_start,
  input  logic         sb_finish,
  input  logic         sr_finish,
  input  logic         mc_finish,
  input  logic         ark_finish,
  input  logic [127:0] sb_result,
  input  logic [127:0] sr_result,
  input  logic [127:0] mc_result,
  input  logic [127:0] ark_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic         error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_SB  = 2'd0,
    OP_SR  = 2'd1,
    OP_MC  = 2'd2,
    OP_ARK = 2'd3
  } op_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;
  // Watchdog value seen in the last tolerated WAIT cycle.
  localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

  state_t       state_r, state_s;
  op_t          op_r, op_s;
  logic [3:0]   round_r, round_s;
  logic [7:0]   wd_r, wd_s;
  logic [127:0] work_r, work_s;

  logic         sel_finish_s;
  logic [127:0] sel_result_s;

  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;
  logic         error_r;
  logic         sb_start_r, sr_start_r, mc_start_r, ark_start_r;

  // Route finish/result of the unit selected by op; the others are ignored.
  always_comb begin
    sel_finish_s = 1'b0;
    sel_result_s = 128'd0;
    case (op_r)
      OP_SB:   begin sel_finish_s = sb_finish;  sel_result_s = sb_result;  end
      OP_SR:   begin sel_finish_s = sr_finish;  sel_result_s = sr_result;  end
      OP_MC:   begin sel_finish_s = mc_finish;  sel_result_s = mc_result;  end
      OP_ARK:  begin sel_finish_s = ark_finish; sel_result_s = ark_result; end
      default: begin sel_finish_s = 1'b0;       sel_result_s = 128'd0;     end
    endcase
  end

  // Next-state, next-op, round, watchdog and working-state logic.
  always_comb begin
    state_s = state_r;
    op_s    = op_r;
    round_s = round_r;
    wd_s    = wd_r;
    work_s  = work_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          work_s  = plaintext;
          round_s = 4'd0;
          op_s    = OP_ARK;
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        wd_s    = 8'd0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (sel_finish_s) begin
          work_s  = sel_result_s;
          state_s = ST_NEXT;
        end else begin
          wd_s = wd_r + 8'd1;
          if (wd_r == WD_LAST) begin
            state_s = ST_ERR;
          end else begin
            state_s = ST_WAIT;
          end
        end
      end
      ST_NEXT: begin
        state_s = ST_ISSUE;
        case (op_r)
          OP_ARK: begin
            if (round_r == LAST_ROUND) begin
              state_s = ST_DONE;
            end else begin
              round_s = round_r + 4'd1;
              op_s    = OP_SB;
            end
          end
          OP_SB:   op_s = OP_SR;
          // The final round skips mixcolumns.
          OP_SR:   op_s = (round_r == LAST_ROUND) ? OP_ARK : OP_MC;
          OP_MC:   op_s = OP_ARK;
          default: state_s = ST_ERR;
        endcase
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_ERR: begin
        state_s = ST_ERR;
      end
      default: begin
        state_s = ST_ERR;
      end
    endcase
  end

  // Core sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      op_r    <= OP_ARK;
      round_r <= 4'd0;
      wd_r    <= 8'd0;
      work_r  <= 128'd0;
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      round_r <= round_s;
      wd_r    <= wd_s;
      work_r  <= work_s;
    end
  end

  // Output flags decoded from the next state so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      error_r     <= 1'b0;
      sb_start_r  <= 1'b0;
      sr_start_r  <= 1'b0;
      mc_start_r  <= 1'b0;
      ark_start_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
      busy_r      <= (state_s == ST_ISSUE) || (state_s == ST_WAIT) || (state_s == ST_NEXT);
      error_r     <= (state_s == ST_ERR);
      sb_start_r  <= (state_s == ST_ISSUE) && (op_s == OP_SB);
      sr_start_r  <= (state_s == ST_ISSUE) && (op_s == OP_SR);
      mc_start_r  <= (state_s == ST_ISSUE) && (op_s == OP_MC);
      ark_start_r <= (state_s == ST_ISSUE) && (op_s == OP_ARK);
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign error       = error_r;
  assign sb_start    = sb_start_r;
  assign sr_start    = sr_start_r;
  assign mc_start    = mc_start_r;
  assign ark_start   = ark_start_r;
  assign unit_state  = work_r;
  assign ciphertext  = work_r;
  assign roundnumber = round_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Directed/randomised bench for aes_round_sequencer. Behavioural AES units
// (built from a plain AES-128 model with key 000102..0f) answer the start
// pulses after a fixed or random latency and log every (op, round) they see.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

  localparam int TIMEOUT = 16;
  localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FORCED = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] plaintext = 128'd0;
  logic         in_ready, out_valid, busy, error;
  logic [127:0] unit_state, ciphertext;
  logic [3:0]   roundnumber;
  logic         sb_start, sr_start, mc_start, ark_start;
  logic         sb_finish = 1'b0, sr_finish = 1'b0, mc_finish = 1'b0, ark_finish = 1'b0;
  logic [127:0] sb_result = 128'd0, sr_result = 128'd0, mc_result = 128'd0, ark_result = 128'd0;

  aes_round_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .plaintext(plaintext),
    .unit_state(unit_state), .roundnumber(roundnumber),
    .sb_start(sb_start), .sr_start(sr_start), .mc_start(mc_start), .ark_start(ark_start),
    .sb_finish(sb_finish), .sr_finish(sr_finish), .mc_finish(mc_finish), .ark_finish(ark_finish),
    .sb_result(sb_result), .sr_result(sr_result), .mc_result(mc_result), .ark_result(ark_result),
    .out_valid(out_valid), .out_ready(out_ready), .ciphertext(ciphertext),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- AES-128 reference model ----------------
  logic [7:0]  sbox_t [256];
  logic [31:0] w [44];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] getb(input logic [127:0] st, input int i);
    return st[127 - 8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] st);
    logic [127:0] r = 128'd0;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox_t[getb(st, i)];
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] st);
    logic [127:0] r = 128'd0;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127 - 8*(rw + 4*c) -: 8] = getb(st, rw + 4*((c + rw) % 4));
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] st);
    logic [127:0] r = 128'd0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = getb(st, 4*c); a1 = getb(st, 4*c+1); a2 = getb(st, 4*c+2); a3 = getb(st, 4*c+3);
      r[127 - 8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      r[127 - 8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      r[127 - 8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      r[127 - 8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return r;
  endfunction

  function automatic logic [127:0] rk(input int r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Apply full AES rounds first..10 to a state.
  function automatic logic [127:0] aes_rounds(input logic [127:0] st, input int first);
    logic [127:0] s = st;
    for (int r = first; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r < 10) s = mix_columns(s);
      s = s ^ rk(r);
    end
    return s;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    return aes_rounds(pt ^ rk(0), 1);
  endfunction

  task automatic build_model();
    logic [7:0] inv, b;
    logic [31:0] t;
    logic [7:0] rcon = 8'h01;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 4; i++) w[i] = KEY[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h000000};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
  endtask

  // ---------------- behavioural units ----------------
  // op codes in the log: 0 SB, 1 SR, 2 MC, 3 ARK
  bit   lat_random = 1'b0;
  int   lat_fix = 1;
  bit   sb_hold = 1'b0, ark_spurious = 1'b0, never_mc = 1'b0, force_r5 = 1'b0;
  int   log_op[$], log_rnd[$];
  int   exp_op[$], exp_rnd[$];
  logic [3:0] prev_start = 4'd0;
  int   pend_op = -1;
  int   pend_cnt = 0;

  always @(negedge clk or posedge rst) begin : unit_models
    logic [3:0] cur;
    int op;
    if (rst) begin
      pend_op = -1; pend_cnt = 0; prev_start = 4'd0;
      sb_finish = 1'b0; sr_finish = 1'b0; mc_finish = 1'b0; ark_finish = 1'b0;
    end else begin
      sb_finish = sb_hold; sr_finish = 1'b0; mc_finish = 1'b0; ark_finish = 1'b0;
      cur = {sb_start, sr_start, mc_start, ark_start};
      if (prev_start != 4'd0) chk("start_single_pulse", 128'(cur), 128'd0);
      prev_start = cur;
      if (pend_op >= 0) begin
        if (ark_spurious && pend_op == 0) begin
          ark_finish = 1'b1;
          ark_result = ~unit_state;
        end
        pend_cnt--;
        if (pend_cnt == 0) begin
          case (pend_op)
            0:       sb_finish = 1'b1;
            1:       sr_finish = 1'b1;
            2:       mc_finish = 1'b1;
            default: ark_finish = 1'b1;
          endcase
          pend_op = -1;
        end
      end
      if (cur != 4'd0) begin
        op = sb_start ? 0 : (sr_start ? 1 : (mc_start ? 2 : 3));
        log_op.push_back(op);
        log_rnd.push_back(int'(roundnumber));
        case (op)
          0:       sb_result = sub_bytes(unit_state);
          1:       sr_result = shift_rows(unit_state);
          2:       mc_result = mix_columns(unit_state);
          default: ark_result = ((force_r5 && roundnumber == 4'd5) ? FORCED : unit_state) ^ rk(int'(roundnumber));
        endcase
        pend_op  = (never_mc && op == 2) ? -1 : op;
        pend_cnt = lat_random ? int'($urandom_range(7, 1)) : lat_fix;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_xfer(input logic [127:0] pt);
    chk("in_ready_idle", 128'(in_ready), 128'd1);
    log_op.delete(); log_rnd.delete();
    plaintext = pt;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts rising edges after the input-transfer edge until out_valid.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 2000) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 2) chk("busy_running", 128'(busy), 128'd1);
    end
    chk("out_valid_seen", 128'(out_valid), 128'd1);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_valid_dropped", 128'(out_valid), 128'd0);
    chk("in_ready_after_pop", 128'(in_ready), 128'd1);
  endtask

  task automatic check_sched();
    int n;
    chk("sched_len", 128'(log_op.size()), 128'(exp_op.size()));
    n = (log_op.size() < exp_op.size()) ? log_op.size() : exp_op.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("sched_%0d", i), 128'({log_op[i], log_rnd[i]}), 128'({exp_op[i], exp_rnd[i]}));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [127:0] pt, pt2, exp_ct;
    int lat, n;

    build_model();
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) begin
        exp_op.push_back(0); exp_rnd.push_back(r);
        exp_op.push_back(1); exp_rnd.push_back(r);
        if (r < 10) begin exp_op.push_back(2); exp_rnd.push_back(r); end
      end
      exp_op.push_back(3); exp_rnd.push_back(r);
    end

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_error", 128'(error), 128'd0);
    chk("rst_unit_state", unit_state, 128'd0);
    chk("rst_ciphertext", ciphertext, 128'd0);
    chk("rst_roundnumber", 128'(roundnumber), 128'd0);
    chk("rst_starts", 128'({sb_start, sr_start, mc_start, ark_start}), 128'd0);

    // Known-answer block at minimum latency
    chk("model_c1", aes_encrypt(C1_PT), C1_CT);
    lat_fix = 1;
    start_xfer(C1_PT);
    wait_done(lat);
    chk("c1_latency", 128'(lat), 128'd120);
    chk("c1_ciphertext", ciphertext, C1_CT);
    check_sched();
    pop();

    // Random plaintexts, random unit latency
    lat_random = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pt = rnd128();
      start_xfer(pt);
      wait_done(lat);
      chk("rand_ciphertext", ciphertext, aes_encrypt(pt));
      check_sched();
      pop();
    end

    // Stale sb_finish held high, spurious ark_finish during SB waits
    sb_hold = 1'b1; ark_spurious = 1'b1;
    start_xfer(C1_PT);
    wait_done(lat);
    chk("spurious_ciphertext", ciphertext, C1_CT);
    check_sched();
    pop();
    sb_hold = 1'b0; ark_spurious = 1'b0;

    // Round-5 ARK sees a forced state; working state must take the ARK result
    force_r5 = 1'b1;
    start_xfer(C1_PT);
    n = 0;
    while (roundnumber != 4'd6 && n < 2000) begin @(posedge clk); n++; #1; end
    chk("r5_ark_state", unit_state, FORCED ^ rk(5));
    wait_done(lat);
    chk("r5_ciphertext", ciphertext, aes_rounds(FORCED ^ rk(5), 6));
    pop();
    force_r5 = 1'b0;

    // Backpressure: hold out_ready low 50 cycles with a new block offered
    pt = rnd128(); pt2 = rnd128();
    exp_ct = aes_encrypt(pt);
    start_xfer(pt);
    wait_done(lat);
    plaintext = pt2;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      chk("bp_ciphertext", ciphertext, exp_ct);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
    end
    pop();
    log_op.delete(); log_rnd.delete();
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_capture", unit_state, pt2);
    wait_done(lat);
    chk("bp_ciphertext2", ciphertext, aes_encrypt(pt2));
    check_sched();
    pop();

    // Reset in the middle of a round-4 WAIT
    lat_random = 1'b0; lat_fix = 7;
    start_xfer(rnd128());
    n = 0;
    while (!(roundnumber == 4'd4 && sb_start) && n < 2000) begin @(posedge clk); n++; #1; end
    chk("mid_sb4_start", 128'(sb_start), 128'd1);
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 128'(busy), 128'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_state", unit_state, 128'd0);
    chk("mid_rst_round", 128'(roundnumber), 128'd0);
    chk("mid_rst_starts", 128'({sb_start, sr_start, mc_start, ark_start}), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lat_random = 1'b1;
    pt = rnd128();
    start_xfer(pt);
    wait_done(lat);
    chk("post_rst_ciphertext", ciphertext, aes_encrypt(pt));
    check_sched();
    pop();

    // Watchdog: mixcolumns never finishes. TIMEOUT WAIT cycles follow the
    // start cycle, and error appears on the edge after the last one.
    never_mc = 1'b1;
    start_xfer(rnd128());
    n = 0;
    while (!mc_start && n < 2000) begin @(posedge clk); n++; #1; end
    chk("wd_mc_start", 128'(mc_start), 128'd1);
    chk("wd_mc_round", 128'(roundnumber), 128'd1);
    n = 0;
    while (!error && n < 100) begin @(posedge clk); n++; #1; end
    chk("wd_cycles", 128'(n), 128'(TIMEOUT + 1));
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk("err_starts", 128'({sb_start, sr_start, mc_start, ark_start}), 128'd0);
      chk("err_in_ready", 128'(in_ready), 128'd0);
      chk("err_error", 128'(error), 128'd1);
    end
    in_valid = 1'b0;
    never_mc = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("err_rst_error", 128'(error), 128'd0);
    chk("err_rst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
